mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: W, 8, operand width; SHALL be even, 4..16; N = W/2 digits, N*N steps.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand pair offered.
REQ-005 Port: in_ready  output  1  controller accepts operands; high iff state IDLE.
REQ-006 Port: a  input  W  multiplicand, sampled on accept.
REQ-007 Port: b  input  W  multiplier, sampled on accept.
REQ-008 Port: abort  input  1  synchronous cancel of current operation.
REQ-009 Port: core_a  output  2  A-digit driven to the external 2x2 multiplier core.
REQ-010 Port: core_b  output  2  B-digit driven to the external 2x2 multiplier core.
REQ-011 Port: core_p  input  4  combinational 2x2 product returned by core in the same cycle.
REQ-012 Port: out_valid  output  1  result available.
REQ-013 Port: out_ready  input  1  consumer takes result.
REQ-014 Port: p  output  2W  result register.
REQ-015 Port: busy  output  1  high iff state RUN.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 Accept: in IDLE with in_valid=1 and abort=0, latch a_reg=a, b_reg=b, clear accumulator, i=0, j=0, go to RUN.
REQ-018 RUN step: core_a = a_reg[2i+1:2i], core_b = b_reg[2j+1:2j]; acc <= acc + (core_p << 2(i+j)).
REQ-019 Step order: j inner (0..N-1), i outer (0..N-1); exactly N*N RUN cycles, one core use per cycle.
REQ-020 Accumulator SHALL be 2W bits; no overflow possible; carries beyond bit 2W-1 never occur.
REQ-021 After last step (i=j=N-1) the cycle's sum SHALL be written to p and FSM goes to DONE; out_valid=1 while in DONE.
REQ-022 Latency: accept at edge T, out_valid high from edge T+N*N+1 (W=8: 17 cycles).
REQ-023 In IDLE and DONE core_a and core_b SHALL be 2'b00.
REQ-024 DONE: p and out_valid held stable until out_valid&out_ready; then go to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-025 p SHALL retain the last completed result through IDLE and RUN until overwritten by the next completion.
REQ-026 in_valid while not IDLE SHALL be ignored; operands not sampled.
REQ-027 abort=1 in RUN or DONE: go to IDLE next edge, discard accumulator, out_valid low, p unchanged; abort in IDLE has no effect and blocks accept that cycle.
REQ-028 abort and out_ready together in DONE: abort wins; result counted as not delivered.

Reset
REQ-029 On rst_n=0 (any state, any cycle): state IDLE, out_valid=0, p=0, acc=0, i=j=0, a_reg=b_reg=0, busy=0, core_a=core_b=0, in_ready=1.
REQ-030 Reset mid-RUN SHALL discard the operation; no out_valid after release until a new accept.

Verification
REQ-031 W=8, a=255, b=255, out_ready=1 -> busy 16 cycles, out_valid at accept+17, p=0xFE01 (65025), then in_ready=1 one cycle later.
REQ-032 W=8, a=0xA5, b=0x3C -> p=0x26AC (9900); a=0, b=0xFF -> p=0; core_a/core_b sequence matches REQ-019 order.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> p, out_valid stable; in_valid pulses during RUN/DONE not accepted.
REQ-034 abort at RUN step 7 -> IDLE next cycle, no out_valid, p keeps previous result; next operands 3x3 -> p=9.
REQ-035 rst_n low at RUN step 10 -> all outputs per REQ-029 immediately; after release 16x16 -> p=256.
REQ-036 W=4 instance, a=15, b=15 -> 4 RUN cycles, out_valid at accept+5, p=225.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential W x W unsigned multiplier controller built around an external 2x2 core.
// Walks N*N digit pairs (j inner, i outer), accumulating shifted partial products.
module mul_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           abort,
  output logic [1:0]     core_a,
  output logic [1:0]     core_b,
  input  logic [3:0]     core_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int N  = W / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_reg, b_reg;
  logic [2*W-1:0]   acc, sum;
  logic [CW-1:0]    i_q, j_q;
  logic             last_i, last_j;

  function automatic logic [1:0] digit(input logic [W-1:0] v, input logic [CW-1:0] k);
    logic [W-1:0] s;
    s = v >> {k, 1'b0};
    return s[1:0];
  endfunction

  // Partial product for digit pair (ii, jj) lands at bit 2*(ii+jj).
  function automatic logic [2*W-1:0] place(input logic [3:0] pp,
                                           input logic [CW-1:0] ii,
                                           input logic [CW-1:0] jj);
    logic [SW-1:0] sh;
    sh = SW'({ii, 1'b0}) + SW'({jj, 1'b0});
    return {{(2*W-4){1'b0}}, pp} << sh;
  endfunction

  assign last_i = (i_q == CW'(N - 1));
  assign last_j = (j_q == CW'(N - 1));
  assign sum    = acc + place(core_p, i_q, j_q);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    core_a    = 2'b00;
    core_b    = 2'b00;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) state_d = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        core_a = digit(a_reg, i_q);
        core_b = digit(b_reg, j_q);
        if (abort)                 state_d = IDLE;
        else if (last_i && last_j) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // abort takes priority: the result is treated as not delivered
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      p       <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid && !abort) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            acc <= '0;
            i_q <= '0;
            j_q <= '0;
          end else begin
            acc <= sum;
            if (last_j) begin
              j_q <= '0;
              i_q <= last_i ? '0 : i_q + CW'(1);
            end else begin
              j_q <= j_q + CW'(1);
            end
            if (last_i && last_j) p <= sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl (W=8 main instance, W=4 side instance).
// Reference: product = a*b, digit schedule from plain index arithmetic.
module tb_mul_seq_ctrl;

  localparam int N8 = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [1:0]  core_a, core_b;
  logic [3:0]  core_p;
  logic [15:0] p;

  logic        iv4, ir4, ov4, or4, busy4, abort4;
  logic [3:0]  a4, b4;
  logic [1:0]  ca4, cb4;
  logic [3:0]  cp4;
  logic [7:0]  p4;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_p;

  // external 2x2 multiplier cores
  assign core_p = {2'b00, core_a} * {2'b00, core_b};
  assign cp4    = {2'b00, ca4} * {2'b00, cb4};

  mul_seq_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .abort(abort), .core_a(core_a), .core_b(core_b),
    .core_p(core_p), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  mul_seq_ctrl #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .abort(abort4), .core_a(ca4), .core_b(cb4),
    .core_p(cp4), .out_valid(ov4), .out_ready(or4),
    .p(p4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one unit after a rising edge; leaves the DUT in its first RUN cycle.
  task automatic accept(input logic [7:0] xa, input logic [7:0] xb);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Checks the digit schedule for steps 0..nsteps-1 while offering junk operands.
  task automatic steps(input logic [7:0] xa, input logic [7:0] xb, input int nsteps);
    int ea, eb;
    for (int k = 0; k < nsteps; k++) begin
      ea = (int'(xa) >> (2 * (k / N8))) & 3;
      eb = (int'(xb) >> (2 * (k % N8))) & 3;
      chk("busy_run", 32'(busy), 1);
      chk("in_ready_run", 32'(in_ready), 0);
      chk("core_a", 32'(core_a), 32'(ea));
      chk("core_b", 32'(core_b), 32'(eb));
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input int hold);
    logic [15:0] exp;
    exp = 16'(int'(xa) * int'(xb));
    accept(xa, xb);
    steps(xa, xb, N8 * N8);
    chk("out_valid_done", 32'(out_valid), 1);
    chk("p_result", 32'(p), 32'(exp));
    chk("busy_done", 32'(busy), 0);
    chk("core_idle", 32'({core_a, core_b}), 0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
      chk("out_valid_hold", 32'(out_valid), 1);
      chk("p_hold", 32'(p), 32'(exp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after", 32'(out_valid), 0);
    chk("in_ready_after", 32'(in_ready), 1);
    chk("p_retained", 32'(p), 32'(exp));
    last_p = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    iv4 = 1'b0; abort4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    last_p = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_p", 32'(p), 0);
    chk("rst_core", 32'({core_a, core_b}), 0);
    chk("rst_in_ready4", 32'(ir4), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // full-scale operands; out_valid in cycle 17 counting the accept cycle as 0
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'hA5, 8'h3C, 0);
    run_op(8'h00, 8'hFF, 0);
    run_op(8'h5A, 8'hC3, 5);

    // abort in IDLE blocks accept
    in_valid = 1'b1; abort = 1'b1; a = 8'd7; b = 8'd7;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_ready", 32'(in_ready), 1);
    chk("abort_idle_busy", 32'(busy), 0);

    // abort at RUN step 7
    accept(8'hC3, 8'h5A);
    steps(8'hC3, 8'h5A, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_ready", 32'(in_ready), 1);
    chk("abort_run_busy", 32'(busy), 0);
    chk("abort_run_p", 32'(p), 32'(last_p));
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 0);
    end
    run_op(8'd3, 8'd3, 0);

    // abort beats out_ready in DONE
    accept(8'h12, 8'h34);
    steps(8'h12, 8'h34, N8 * N8);
    chk("done_valid", 32'(out_valid), 1);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    chk("abort_done_valid", 32'(out_valid), 0);
    chk("abort_done_ready", 32'(in_ready), 1);
    chk("abort_done_p", 32'(p), 32'h12 * 32'h34);
    last_p = 16'(32'h12 * 32'h34);

    // reset at RUN step 10
    accept(8'hFF, 8'hFF);
    steps(8'hFF, 8'hFF, 10);
    rst_n = 1'b0;
    #1;
    chk("rstrun_ready", 32'(in_ready), 1);
    chk("rstrun_busy", 32'(busy), 0);
    chk("rstrun_valid", 32'(out_valid), 0);
    chk("rstrun_p", 32'(p), 0);
    chk("rstrun_core", 32'({core_a, core_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("rstrun_no_valid", 32'(out_valid), 0);
    end
    run_op(8'd16, 8'd16, 0);

    // randomized operands and backpressure
    for (int r = 0; r < 24; r++) begin
      run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) tick();
    end

    // W=4 instance: 4 RUN cycles, result in cycle 5
    chk("w4_ready", 32'(ir4), 1);
    iv4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    tick();
    iv4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("w4_busy", 32'(busy4), 1);
      chk("w4_core_a", 32'(ca4), 32'(3));
      chk("w4_core_b", 32'(cb4), 32'(3));
      tick();
    end
    chk("w4_valid", 32'(ov4), 1);
    chk("w4_p", 32'(p4), 225);
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk("w4_ready_after", 32'(ir4), 1);
    chk("w4_valid_after", 32'(ov4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
